// File: rtl/mlp_epoch_sequencer_pkg.sv
// rtl/mlp_epoch_sequencer_pkg.sv - shared fixed-point type, constants and FSM states
package mlp_epoch_sequencer_pkg;

  // Q8.8 signed fixed point used on every MLP data path.
  typedef logic signed [15:0] sfp;

  localparam sfp ONE  = 16'sh0100;
  localparam sfp HALF = 16'sh0080;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    EVAL,
    DRAIN,
    DONE
  } seq_state_e;

  // Class decision used by scoring: true when the value falls below the threshold.
  function automatic logic below(input sfp a, input sfp t);
    return $signed(a) < $signed(t);
  endfunction

endpackage

// File: rtl/mlp_score_pipe.sv
// rtl/mlp_score_pipe.sv - eval-sample delay line, threshold compare and running correct counter
module mlp_score_pipe
  import mlp_epoch_sequencer_pkg::*;
#(
  parameter int OUTPUTS      = 1,
  parameter int PRED_LATENCY = 1,
  parameter int CW           = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  sfp   [OUTPUTS-1:0]   in_expected,
  input  sfp   [OUTPUTS-1:0]   prediction,
  input  sfp                   threshold,
  output logic [CW-1:0]        count_final
);

  logic [PRED_LATENCY-1:0] vld;
  sfp   [OUTPUTS-1:0]      exp_q [PRED_LATENCY];
  logic [CW-1:0]           count;
  logic                    hit;
  logic                    out_valid;

  // Carry each eval sample's target alongside its valid bit until its prediction is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < PRED_LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
    exp_q[0] <= in_expected;
    for (int i = 1; i < PRED_LATENCY; i++) begin
      exp_q[i] <= exp_q[i-1];
    end
  end

  assign out_valid = vld[PRED_LATENCY-1];

  // A sample is correct when prediction and target land on the same side of the threshold for every output.
  always_comb begin
    hit = 1'b1;
    for (int j = 0; j < OUTPUTS; j++) begin
      if (below(prediction[j], threshold) != below(exp_q[PRED_LATENCY-1][j], threshold)) begin
        hit = 1'b0;
      end
    end
  end

  // The final value includes the sample emerging this cycle so the sequencer can latch it at pass end.
  assign count_final = count + CW'(out_valid && hit);

  // Running count of correct samples within the current eval pass.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count_final;
    end
  end

endmodule

// File: rtl/mlp_epoch_sequencer.sv
// rtl/mlp_epoch_sequencer.sv - dataset store and train/eval epoch sequencer feeding an MLP
module mlp_epoch_sequencer
  import mlp_epoch_sequencer_pkg::*;
#(
  parameter int INPUTS       = 2,
  parameter int OUTPUTS      = 1,
  parameter int NUM_SAMPLES  = 4,
  parameter int NUM_EPOCHS   = 100,
  parameter int PRED_LATENCY = 1,
  localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int EW = (NUM_EPOCHS > 1) ? $clog2(NUM_EPOCHS + 1) : 1,
  localparam int CW = $clog2(NUM_SAMPLES + 1),
  localparam int DW = $clog2(PRED_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  sfp   [INPUTS-1:0]    load_values,
  input  sfp   [OUTPUTS-1:0]   load_expected,
  input  logic                 start,
  input  sfp                   threshold,
  output sfp   [INPUTS-1:0]    values,
  output sfp   [OUTPUTS-1:0]   expected,
  output logic                 training,
  input  sfp   [OUTPUTS-1:0]   prediction,
  output logic                 busy,
  output logic [EW-1:0]        epoch,
  output logic                 epoch_done,
  output logic [CW-1:0]        correct_count,
  output logic                 done
);

  localparam logic [AW-1:0] LAST_K     = AW'(NUM_SAMPLES - 1);
  localparam logic [EW-1:0] LAST_EPOCH = EW'(NUM_EPOCHS - 1);
  localparam logic [DW-1:0] DRAIN_END  = DW'(PRED_LATENCY);

  sfp [INPUTS-1:0]  mem_v [NUM_SAMPLES];
  sfp [OUTPUTS-1:0] mem_e [NUM_SAMPLES];

  seq_state_e       state;
  logic [AW-1:0]    k;
  logic [DW-1:0]    dcnt;
  sfp               thr_q;
  logic             eval_valid;
  logic             score_clear;
  logic [CW-1:0]    count_final;
  logic             idle_ok;

  // The final DONE cycle still has busy high, so commands there are ignored too.
  assign idle_ok = ((state == IDLE) || (state == DONE)) && !busy;

  // Dataset write port; deliberately not reset so contents survive rst and runs.
  always_ff @(posedge clk) begin
    if (load_en && idle_ok && (int'(load_addr) < NUM_SAMPLES)) begin
      mem_v[load_addr] <= load_values;
      mem_e[load_addr] <= load_expected;
    end
  end

  // Epoch sequencer: issues sample indices, registers MLP-facing outputs, and closes each eval pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      dcnt          <= '0;
      thr_q         <= '0;
      values        <= '0;
      expected      <= '0;
      training      <= 1'b0;
      eval_valid    <= 1'b0;
      score_clear   <= 1'b0;
      busy          <= 1'b0;
      epoch         <= '0;
      epoch_done    <= 1'b0;
      correct_count <= '0;
      done          <= 1'b0;
    end else begin
      values      <= '0;
      expected    <= '0;
      training    <= 1'b0;
      eval_valid  <= 1'b0;
      score_clear <= 1'b0;
      epoch_done  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (start) begin
            thr_q <= threshold;
            state <= TRAIN;
            k     <= '0;
            epoch <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        TRAIN: begin
          values   <= mem_v[k];
          expected <= mem_e[k];
          training <= 1'b1;
          if (k == LAST_K) begin
            k           <= '0;
            state       <= EVAL;
            score_clear <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        EVAL: begin
          values     <= mem_v[k];
          expected   <= mem_e[k];
          eval_valid <= 1'b1;
          if (k == LAST_K) begin
            k     <= '0;
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == DRAIN_END) begin
            epoch_done    <= 1'b1;
            correct_count <= count_final;
            if (epoch == LAST_EPOCH) begin
              state <= DONE;
            end else begin
              epoch <= epoch + 1'b1;
              k     <= '0;
              state <= TRAIN;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mlp_score_pipe #(
    .OUTPUTS      (OUTPUTS),
    .PRED_LATENCY (PRED_LATENCY),
    .CW           (CW)
  ) u_score (
    .clk         (clk),
    .rst         (rst),
    .clear       (score_clear),
    .in_valid    (eval_valid),
    .in_expected (expected),
    .prediction  (prediction),
    .threshold   (thr_q),
    .count_final (count_final)
  );

endmodule

// File: tb/tb_mlp_epoch_sequencer.sv
// tb/tb_mlp_epoch_sequencer.sv - self-checking bench for mlp_epoch_sequencer with stub MLPs
module tb_mlp_epoch_sequencer;
  import mlp_epoch_sequencer_pkg::*;

  localparam int NI = 2;
  localparam int NO = 1;
  localparam int NS = 4;
  localparam int NE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_s [2];
  logic           start_s [2];
  logic           load_en_s [2];
  logic [1:0]     load_addr;
  sfp   [NI-1:0]  load_values;
  sfp   [NO-1:0]  load_expected;
  sfp             threshold;
  sfp   [NI-1:0]  values_s [2];
  sfp   [NO-1:0]  expected_s [2];
  logic           training_s [2];
  sfp   [NO-1:0]  prediction_s [2];
  logic           busy_s [2];
  logic [1:0]     epoch_s [2];
  logic           epoch_done_s [2];
  logic [2:0]     cc_s [2];
  logic           done_s [2];

  int total = 0;
  int bad = 0;
  int mode = 0;
  sfp bias = '0;

  sfp [NI-1:0] data_v [NS];
  sfp [NO-1:0] data_e [NS];

  // Stub MLP transfer function selected by mode.
  function automatic sfp stub_f(input sfp [NI-1:0] v, input sfp [NO-1:0] e);
    case (mode)
      0: return e[0];
      1: return sfp'(0);
      2: return ONE;
      default: return sfp'(v[0] + v[1] - bias);
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    sfp chain [L];

    // Stub MLP: the prediction for a driven sample appears L cycles later.
    always @(posedge clk) begin
      chain[0] <= stub_f(values_s[g], expected_s[g]);
      for (int i = 1; i < L; i++) chain[i] <= chain[i-1];
    end

    assign prediction_s[g] = chain[L-1];

    mlp_epoch_sequencer #(
      .INPUTS(NI), .OUTPUTS(NO), .NUM_SAMPLES(NS), .NUM_EPOCHS(NE), .PRED_LATENCY(L)
    ) u_dut (
      .clk           (clk),
      .rst           (rst_s[g]),
      .load_en       (load_en_s[g]),
      .load_addr     (load_addr),
      .load_values   (load_values),
      .load_expected (load_expected),
      .start         (start_s[g]),
      .threshold     (threshold),
      .values        (values_s[g]),
      .expected      (expected_s[g]),
      .training      (training_s[g]),
      .prediction    (prediction_s[g]),
      .busy          (busy_s[g]),
      .epoch         (epoch_s[g]),
      .epoch_done    (epoch_done_s[g]),
      .correct_count (cc_s[g]),
      .done          (done_s[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference accuracy: count samples whose stub prediction matches the target's class.
  function automatic int model_count();
    int n = 0;
    for (int s = 0; s < NS; s++) begin
      if (($signed(stub_f(data_v[s], data_e[s])) < $signed(threshold)) ==
          ($signed(data_e[s][0]) < $signed(threshold)))
        n++;
    end
    return n;
  endfunction

  task automatic pulse_reset(input int d);
    @(posedge clk); #1 rst_s[d] = 1'b1;
    @(posedge clk); #1 rst_s[d] = 1'b0;
  endtask

  task automatic load_all();
    for (int s = 0; s < NS; s++) begin
      @(posedge clk); #1;
      load_en_s[0] = 1'b1; load_en_s[1] = 1'b1;
      load_addr = 2'(s); load_values = data_v[s]; load_expected = data_e[s];
    end
    @(posedge clk); #1;
    load_en_s[0] = 1'b0; load_en_s[1] = 1'b0;
  endtask

  task automatic check_idle(input int d, input string tag);
    chk({tag, "_busy"}, 32'(busy_s[d]), 0);
    chk({tag, "_epoch"}, 32'(epoch_s[d]), 0);
    chk({tag, "_training"}, 32'(training_s[d]), 0);
    chk({tag, "_epoch_done"}, 32'(epoch_done_s[d]), 0);
    chk({tag, "_done"}, 32'(done_s[d]), 0);
    chk({tag, "_cc"}, 32'(cc_s[d]), 0);
    chk({tag, "_values"}, 32'(values_s[d]), 0);
  endtask

  // One full run on DUT d, checking sample order, pass lengths, scoring, latency and completion.
  task automatic run(input int d, input int disturb);
    int lat = (d == 0) ? 1 : 3;
    int cyc = 0, ne = 0, tcnt = 0, ecnt = 0, last_eval = 0, expcnt;
    logic fin = 1'b0;
    expcnt = model_count();
    @(posedge clk); #1 start_s[d] = 1'b1;
    @(posedge clk); #1 start_s[d] = 1'b0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_after_start", 32'(busy_s[d]), 1);
      if (disturb != 0 && cyc == 12) begin
        start_s[d] = 1'b1; load_en_s[d] = 1'b1; load_addr = 2'd0;
        load_values = {sfp'(16'sh7777), sfp'(16'sh7777)}; load_expected = sfp'(16'sh7777);
      end else if (disturb != 0 && cyc == 13) begin
        start_s[d] = 1'b0; load_en_s[d] = 1'b0;
      end
      if (training_s[d]) begin
        if (tcnt < NS) begin
          chk("train_values", 32'(values_s[d]), 32'(data_v[tcnt]));
          chk("train_expected", 32'(expected_s[d]), 32'(data_e[tcnt]));
        end
        tcnt++;
      end else if (tcnt == NS && ecnt < NS) begin
        chk("eval_values", 32'(values_s[d]), 32'(data_v[ecnt]));
        chk("eval_expected", 32'(expected_s[d]), 32'(data_e[ecnt]));
        ecnt++;
        if (ecnt == NS) last_eval = cyc;
      end
      if (epoch_done_s[d]) begin
        ne++;
        chk("train_len", 32'(tcnt), NS);
        chk("eval_len", 32'(ecnt), NS);
        chk("correct_count", 32'(cc_s[d]), 32'(expcnt));
        chk("epoch_done_latency", 32'(cyc - last_eval), 32'(lat + 1));
        chk("epoch_at_done", 32'(epoch_s[d]), (ne < NE) ? 32'(ne) : 32'(NE - 1));
        tcnt = 0; ecnt = 0;
        if (ne == NE) begin
          chk("busy_at_last_pulse", 32'(busy_s[d]), 1);
          chk("done_at_last_pulse", 32'(done_s[d]), 0);
          @(negedge clk);
          chk("done_after", 32'(done_s[d]), 1);
          chk("busy_after", 32'(busy_s[d]), 0);
          chk("epoch_done_width", 32'(epoch_done_s[d]), 0);
          fin = 1'b1;
        end
      end
    end
    chk("run_finished", 32'(fin), 1);
  endtask

  initial begin
    int n;
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    load_en_s[0] = 1'b0; load_en_s[1] = 1'b0;
    load_addr = '0; load_values = '0; load_expected = '0; threshold = HALF;
    repeat (3) @(posedge clk);
    #1 rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");

    data_v[0][0] = '0;  data_v[0][1] = '0;  data_e[0][0] = '0;
    data_v[1][0] = '0;  data_v[1][1] = ONE; data_e[1][0] = ONE;
    data_v[2][0] = ONE; data_v[2][1] = '0;  data_e[2][0] = ONE;
    data_v[3][0] = ONE; data_v[3][1] = ONE; data_e[3][0] = '0;
    load_all();

    mode = 0; run(0, 0); run(1, 0);
    mode = 1; run(0, 0);
    mode = 2; run(0, 0);
    mode = 0; run(0, 1);
    run(0, 0);

    // Abort during the eval pass of epoch 1, then expect a clean full rerun.
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    n = 0;
    while (!(epoch_s[0] == 2'd1 && training_s[0]) && n < 200) begin @(negedge clk); n++; end
    while (training_s[0] && n < 200) begin @(negedge clk); n++; end
    chk("reach_eval_epoch1", 32'(n < 200), 1);
    chk("mid_eval_busy", 32'(busy_s[0]), 1);
    rst_s[0] = 1'b1;
    @(posedge clk); #1 rst_s[0] = 1'b0;
    @(negedge clk);
    check_idle(0, "abort");
    run(0, 0);

    for (int it = 0; it < 3; it++) begin
      for (int s = 0; s < NS; s++) begin
        data_v[s][0] = sfp'(int'($urandom_range(0, 1024)) - 512);
        data_v[s][1] = sfp'(int'($urandom_range(0, 1024)) - 512);
        data_e[s][0] = sfp'(int'($urandom_range(0, 1024)) - 512);
      end
      threshold = sfp'(int'($urandom_range(0, 512)) - 256);
      bias = sfp'(int'($urandom_range(0, 512)) - 256);
      mode = 3;
      load_all();
      run(0, 0);
      run(1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
